ac_sequencer: RTL
=================

// Module: ac_sequencer
// PURPOSE
//  Instruction sequencer and owner of the 16-bit accumulator (AC) and carry (E) of the basic computer.
//  Accepts one instruction at a time and fetches memory operands (direct or indirect) over a req/ack port.
//  Generates the timing count and executes the AC-affecting memory-reference, register-reference and I/O instructions.
//  Sits between the instruction fetch unit / memory and the AC datapath; replaces free-running D/T control gating.
// PARAMETERS
//  ADDR_W       12  memory address width (IR[11:0])
//  INPR_W       8   input register width, loaded into AC[INPR_W-1:0]
//  MEM_TIMEOUT  15  max cycles MEM_REQ may stay high without MEM_ACK before abort
// PORTS
//  CLK       in   1       rising-edge clock
//  RST_N     in   1       asynchronous, active-low reset
//  IR_VALID  in   1       instruction offered
//  IR        in   16      instruction: [15]=I, [14:12]=opcode, [11:0]=address / B bits
//  IR_READY  out  1       sequencer idle, will accept IR this cycle
//  MEM_REQ   out  1       operand/address read request, held until ack
//  MEM_ADDR  out  ADDR_W  read address, stable while MEM_REQ=1
//  MEM_ACK   in   1       read complete, MEM_DATA valid this cycle
//  MEM_DATA  in   16      read data
//  INPR      in   INPR_W  input character
//  FGI       in   1       input flag; INP executes only when 1
//  FGI_CLR   out  1       1-cycle pulse when INP executes
//  AC        out  16      accumulator
//  E         out  1       carry/extend bit
//  SC        out  4       sequence count of current instruction
//  BUSY      out  1       instruction in progress
//  HALT      out  1       sticky, set by HLT
//  ERR       out  1       sticky, set by memory timeout
// BEHAVIOUR
//  Reset (async): AC=0, E=0, SC=0, state IDLE, IR_READY=1, MEM_REQ=0, MEM_ADDR=0, FGI_CLR=0, BUSY=0, HALT=0, ERR=0.
//  All outputs registered. States: IDLE, DECODE, IND, OPFETCH, EXEC.
//  IDLE: IR_READY=1 unless HALT|ERR. IR_VALID&IR_READY -> latch IR, SC=1, BUSY=1, go DECODE. IR_VALID ignored when not IDLE.
//  DECODE (1 cycle), by opcode:
//   - 0 AND, 1 ADD, 2 LDA: MEM_ADDR=IR[11:0], MEM_REQ=1; I=1 -> IND, else -> OPFETCH.
//   - 3..6: no AC effect; complete -> IDLE.
//   - 7: -> EXEC.
//  IND: hold MEM_REQ until MEM_ACK; on ack MEM_ADDR=MEM_DATA[11:0], MEM_REQ stays 1, go OPFETCH.
//  OPFETCH: hold MEM_REQ until MEM_ACK; on ack latch DR=MEM_DATA, MEM_REQ=0, go EXEC.
//  MEM_ACK is sampled only while MEM_REQ=1; an ack in the first request cycle is accepted. Stray acks ignored.
//  Timeout: wait counter resets on each new request. After MEM_TIMEOUT cycles of REQ without ACK: MEM_REQ=0, ERR=1,
//   AC/E unchanged, -> IDLE.
//  EXEC (1 cycle), AC/E updated at end of cycle:
//   - AND: AC=AC&DR. ADD: {E,AC}=AC+DR (17-bit, carry to E). LDA: AC=DR.
//   - Register-ref (I=0): only highest-priority set B bit acts:
//     B11 CLA AC=0 > B10 CLE E=0 > B9 CMA AC=~AC > B8 CME E=~E > B7 CIR {AC,E}={E,AC} rotate right
//     > B6 CIL {E,AC}={AC,E} rotate left > B5 INC AC=AC+1 (wraps FFFF->0000, E unchanged) > B0 HLT HALT=1.
//     B4..B1 and all-zero: NOP.
//   - I/O (I=1): B11 INP with FGI=1 -> AC[INPR_W-1:0]=INPR, upper bits kept, FGI_CLR pulse. Otherwise NOP.
//  After EXEC or completion: -> IDLE, SC=0, BUSY=0.
//  SC increments every cycle while BUSY, saturates at 15.
//  Latency (accept at cycle 0): register-ref updates AC at end of cycle 2; direct AND/ADD/LDA with immediate
//   acks at end of cycle 3; indirect adds one cycle per ack wait. IR_READY returns the cycle after update.
//  HALT and ERR stay set until RST_N; IR_READY stays 0. RST_N low mid-operation aborts immediately; MEM_REQ drops
//   asynchronously.
// TESTING
//  1. Reset, IR=7800 (CLA) then IR=7020 (INC) x3 -> AC=0003, E=0, SC=0 and IR_READY=1 after each.
//  2. AC=FFFF, E=0; IR=1010 (ADD direct); ack MEM_DATA=0001 on 1st cycle -> MEM_ADDR=010, AC=0000, E=1,
//     update at end of cycle 3.
//  3. IR=A020 (LDA indirect); ack 1: data 0345 after 2-cycle wait; ack 2: data 1234 -> 2nd MEM_ADDR=345, AC=1234.
//  4. AC=8001, E=1; IR=7080 (CIR) -> AC=C000, E=1; then IR=7040 (CIL) -> AC=8001, E=1.
//  5. IR=0020 (AND), never ack -> MEM_REQ drops after 15 cycles, ERR=1, AC unchanged, IR_READY stays 0.
//  6. IR=F800 with FGI=0 -> AC unchanged. With FGI=1, INPR=5A, AC=1200 -> AC=125A, one FGI_CLR pulse.
//     Then IR=7001 -> HALT=1, IR_VALID ignored; RST_N pulse mid-OPFETCH clears all.

Source files
------------

// File: rtl/ac_sequencer_if.sv
// Handshake bundle between the AC sequencer and its fetch unit, memory and I/O flag.
// The master side is the sequencer; the slave side is the surrounding system.
interface ac_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int INPR_W = 8
);
    logic              ir_valid;
    logic [15:0]       ir;
    logic              ir_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_data;
    logic [INPR_W-1:0] inpr;
    logic              fgi;
    logic              fgi_clr;
    logic [15:0]       ac;
    logic              e;
    logic [3:0]        sc;
    logic              busy;
    logic              halt;
    logic              err;

    modport master (
        input  ir_valid, ir, mem_ack, mem_data, inpr, fgi,
        output ir_ready, mem_req, mem_addr, fgi_clr, ac, e, sc, busy, halt, err
    );

    modport slave (
        output ir_valid, ir, mem_ack, mem_data, inpr, fgi,
        input  ir_ready, mem_req, mem_addr, fgi_clr, ac, e, sc, busy, halt, err
    );
endinterface

// File: rtl/ac_sequencer.sv
// Instruction sequencer owning AC and E: accepts one instruction, fetches direct or
// indirect operands over a req/ack port, and executes AC-affecting instructions.
module ac_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int INPR_W      = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ac_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_IND     = 3'd2;
    localparam logic [2:0] S_OPFETCH = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam int         WAIT_W    = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]        r_state;
    logic [15:0]       r_ir;
    logic [15:0]       r_dr;
    logic [15:0]       r_ac;
    logic              r_e;
    logic [3:0]        r_sc;
    logic              r_busy;
    logic              r_halt;
    logic              r_err;
    logic              r_ir_ready;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_fgi_clr;
    logic [WAIT_W-1:0] r_wait;

    logic [2:0]        w_state_nxt;
    logic [15:0]       w_ir_nxt;
    logic [15:0]       w_dr_nxt;
    logic [15:0]       w_ac_nxt;
    logic              w_e_nxt;
    logic [3:0]        w_sc_nxt;
    logic              w_busy_nxt;
    logic              w_halt_nxt;
    logic              w_err_nxt;
    logic              w_ir_ready_nxt;
    logic              w_mem_req_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              w_fgi_clr_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_done;
    logic [3:0]        w_sc_inc;
    logic [2:0]        w_op;

    assign w_sc_inc = (r_sc == 4'hF) ? r_sc : r_sc + 4'd1;
    assign w_op     = r_ir[14:12];

    always_comb begin
        w_state_nxt    = r_state;
        w_ir_nxt       = r_ir;
        w_dr_nxt       = r_dr;
        w_ac_nxt       = r_ac;
        w_e_nxt        = r_e;
        w_sc_nxt       = r_sc;
        w_busy_nxt     = r_busy;
        w_halt_nxt     = r_halt;
        w_err_nxt      = r_err;
        w_ir_ready_nxt = r_ir_ready;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_fgi_clr_nxt  = 1'b0;
        w_wait_nxt     = r_wait;
        w_done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.ir_valid && r_ir_ready) begin
                    w_ir_nxt       = bus.ir;
                    w_sc_nxt       = 4'd1;
                    w_busy_nxt     = 1'b1;
                    w_ir_ready_nxt = 1'b0;
                    w_state_nxt    = S_DECODE;
                end
            end

            S_DECODE: begin
                w_sc_nxt = w_sc_inc;
                if (w_op <= 3'd2) begin
                    w_mem_addr_nxt = r_ir[ADDR_W-1:0];
                    w_mem_req_nxt  = 1'b1;
                    w_wait_nxt     = '0;
                    w_state_nxt    = r_ir[15] ? S_IND : S_OPFETCH;
                end else if (w_op == 3'd7) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_done = 1'b1;
                end
            end

            S_IND, S_OPFETCH: begin
                w_sc_nxt = w_sc_inc;
                if (bus.mem_ack) begin
                    w_wait_nxt = '0;
                    if (r_state == S_IND) begin
                        // Pointer word becomes the operand address; request stays up.
                        w_mem_addr_nxt = bus.mem_data[ADDR_W-1:0];
                        w_state_nxt    = S_OPFETCH;
                    end else begin
                        w_dr_nxt      = bus.mem_data;
                        w_mem_req_nxt = 1'b0;
                        w_state_nxt   = S_EXEC;
                    end
                end else if (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    w_mem_req_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_done        = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end

            S_EXEC: begin
                w_done = 1'b1;
                if (w_op == 3'd7) begin
                    if (!r_ir[15]) begin
                        // Register-reference: only the highest-priority set B bit acts.
                        if (r_ir[11])      w_ac_nxt = 16'h0000;
                        else if (r_ir[10]) w_e_nxt  = 1'b0;
                        else if (r_ir[9])  w_ac_nxt = ~r_ac;
                        else if (r_ir[8])  w_e_nxt  = ~r_e;
                        else if (r_ir[7]) begin
                            w_ac_nxt = {r_e, r_ac[15:1]};
                            w_e_nxt  = r_ac[0];
                        end else if (r_ir[6]) begin
                            w_ac_nxt = {r_ac[14:0], r_e};
                            w_e_nxt  = r_ac[15];
                        end else if (r_ir[5]) w_ac_nxt   = r_ac + 16'd1;
                        else if (r_ir[0])     w_halt_nxt = 1'b1;
                    end else if (r_ir[11] && bus.fgi) begin
                        w_ac_nxt[INPR_W-1:0] = bus.inpr;
                        w_fgi_clr_nxt        = 1'b1;
                    end
                end else begin
                    case (w_op)
                        3'd0:    w_ac_nxt = r_ac & r_dr;
                        3'd1:    {w_e_nxt, w_ac_nxt} = {1'b0, r_ac} + {1'b0, r_dr};
                        default: w_ac_nxt = r_dr;
                    endcase
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        if (w_done) begin
            w_state_nxt    = S_IDLE;
            w_sc_nxt       = 4'd0;
            w_busy_nxt     = 1'b0;
            w_ir_ready_nxt = !(w_halt_nxt || w_err_nxt);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_ir       <= '0;
            r_dr       <= '0;
            r_ac       <= '0;
            r_e        <= 1'b0;
            r_sc       <= '0;
            r_busy     <= 1'b0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
            r_ir_ready <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_fgi_clr  <= 1'b0;
            r_wait     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir       <= w_ir_nxt;
            r_dr       <= w_dr_nxt;
            r_ac       <= w_ac_nxt;
            r_e        <= w_e_nxt;
            r_sc       <= w_sc_nxt;
            r_busy     <= w_busy_nxt;
            r_halt     <= w_halt_nxt;
            r_err      <= w_err_nxt;
            r_ir_ready <= w_ir_ready_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_fgi_clr  <= w_fgi_clr_nxt;
            r_wait     <= w_wait_nxt;
        end
    end

    assign bus.ir_ready = r_ir_ready;
    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;
    assign bus.fgi_clr  = r_fgi_clr;
    assign bus.ac       = r_ac;
    assign bus.e        = r_e;
    assign bus.sc       = r_sc;
    assign bus.busy     = r_busy;
    assign bus.halt     = r_halt;
    assign bus.err      = r_err;
endmodule
